// File: rtl/microcode_sequencer_if.sv
// Bundle of ROM fields, core handshakes and sequencer outputs shared between
// the microcode sequencer (slave) and whatever drives it (master).
interface microcode_sequencer_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned JADDR_W = 7,
    parameter int unsigned OPC_W   = 8
);
    logic               start;
    logic               stall;
    logic               z_flag;
    logic [OPC_W-1:0]   opcode;
    logic               BT;
    logic [1:0]         condition;
    logic [JADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0]  reg_out;
    logic               busy;
    logic               done;
    logic               illegal_op;

    modport master (
        output start, stall, z_flag, opcode, BT, condition, jump_addr,
        input  reg_out, busy, done, illegal_op
    );

    modport slave (
        input  start, stall, z_flag, opcode, BT, condition, jump_addr,
        output reg_out, busy, done, illegal_op
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Micro-program counter: registers the next microcode ROM address every clock
// from the ROM's BT/condition/jump_addr fields, the Z flag and the opcode.
module microcode_sequencer #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned JADDR_W     = 7,
    parameter int unsigned OPC_W       = 8,
    parameter int unsigned UCODE_DEPTH = 86,
    parameter int unsigned FETCH_ADDR  = 1,
    parameter int unsigned END_ADDR    = 80
) (
    input  logic                  clk,
    input  logic                  rstn,
    microcode_sequencer_if.slave  bus
);
    // state | meaning
    // IDLE  | waiting for start, reg_out parked at 0
    // RUN   | stepping through microcode, busy=1
    // HALT  | end-of-program self-loop reached, done=1, reg_out=END_ADDR
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(UCODE_DEPTH);
    localparam logic [ADDR_W-1:0] FETCH_A = ADDR_W'(FETCH_ADDR);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] reg_out_q, reg_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              illegal_op_q, illegal_op_d;

    logic [ADDR_W-1:0] opc_ext, jmp_ext, inc_addr, next_addr;
    logic              bad_dispatch;

    assign opc_ext  = ADDR_W'(bus.opcode);
    assign jmp_ext  = ADDR_W'(bus.jump_addr);
    assign inc_addr = reg_out_q + ADDR_W'(1);

    // Candidate address for a non-stalled RUN cycle; reserved condition 11 acts as 00.
    always_comb begin
        next_addr    = jmp_ext;
        bad_dispatch = 1'b0;
        if (bus.BT) begin
            next_addr    = opc_ext;
            bad_dispatch = (opc_ext >= DEPTH_A);
        end else begin
            case (bus.condition)
                2'b01:   next_addr = bus.z_flag ? jmp_ext : inc_addr;
                2'b10:   next_addr = bus.z_flag ? inc_addr : jmp_ext;
                default: next_addr = jmp_ext;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        reg_out_d    = reg_out_q;
        illegal_op_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                reg_out_d = '0;
                if (bus.start) begin
                    reg_out_d = FETCH_A;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (bad_dispatch) begin
                        reg_out_d    = '0;
                        state_d      = S_IDLE;
                        illegal_op_d = 1'b1;
                    end else if (next_addr == '0) begin
                        reg_out_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        reg_out_d = next_addr;
                        if (reg_out_q == END_A && next_addr == END_A) begin
                            state_d = S_HALT;
                        end
                    end
                end
            end
            S_HALT: begin
                reg_out_d = END_A;
                if (bus.start) begin
                    reg_out_d = FETCH_A;
                    state_d   = S_RUN;
                end
            end
            default: begin
                reg_out_d = '0;
                state_d   = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            reg_out_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            reg_out_q    <= reg_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign bus.reg_out    = reg_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.illegal_op = illegal_op_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: directed scenarios then random
// stimulus, checked against a behavioural model of the sequencing rules.
module tb_microcode_sequencer;
    localparam int DEPTH = 86;
    localparam int FETCH = 1;
    localparam int ENDA  = 80;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        int   addr;
        logic busy;
        logic done;
        logic ill;
    } exp_t;

    logic clk;
    logic rstn;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   cyc;

    int   m_addr;
    int   m_mode;
    logic m_ill;

    microcode_sequencer_if #(.ADDR_W(16), .JADDR_W(7), .OPC_W(8)) bus ();

    microcode_sequencer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of one clock edge, written directly from the sequencing rules.
    task automatic model_step(input logic r, input logic st, input logic sl,
                              input logic z, input logic bt, input logic [1:0] c,
                              input int op, input int j);
        int nxt;
        m_ill = 1'b0;
        if (!r) begin
            m_addr = 0;
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE || m_mode == M_HALT) begin
            if (st) begin
                m_addr = FETCH;
                m_mode = M_RUN;
            end else begin
                m_addr = (m_mode == M_HALT) ? ENDA : 0;
            end
        end else if (!sl) begin
            if (bt && op >= DEPTH) begin
                m_addr = 0;
                m_mode = M_IDLE;
                m_ill  = 1'b1;
            end else begin
                if (bt)           nxt = op;
                else if (c == 1)  nxt = z ? j : m_addr + 1;
                else if (c == 2)  nxt = z ? m_addr + 1 : j;
                else              nxt = j;
                nxt = nxt % 65536;
                if (nxt == 0) begin
                    m_mode = M_IDLE;
                end else if (m_addr == ENDA && nxt == ENDA) begin
                    m_mode = M_HALT;
                end
                m_addr = nxt;
            end
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic sl,
                         input logic z, input logic bt, input logic [1:0] c,
                         input int op, input int j);
        exp_t e;
        @(negedge clk);
        rstn          = r;
        bus.start     = st;
        bus.stall     = sl;
        bus.z_flag    = z;
        bus.BT        = bt;
        bus.condition = c;
        bus.opcode    = 8'(op);
        bus.jump_addr = 7'(j);
        model_step(r, st, sl, z, bt, c, op, j);
        e.addr = m_addr;
        e.busy = (m_mode == M_RUN);
        e.done = (m_mode == M_HALT);
        e.ill  = m_ill;
        exp_q.push_back(e);
    endtask

    task automatic nop_jump(input int j);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, j);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (int'(bus.reg_out) !== e.addr || bus.busy !== e.busy ||
                    bus.done !== e.done || bus.illegal_op !== e.ill) begin
                    n_bad++;
                    $display("FAIL seq_out t=%0t: got reg_out=%0d busy=%b done=%b illegal_op=%b, want reg_out=%0d busy=%b done=%b illegal_op=%b",
                             $time, bus.reg_out, bus.busy, bus.done, bus.illegal_op,
                             e.addr, e.busy, e.done, e.ill);
                end
            end
        end
    end

    initial begin : stimulus
        logic st, sl, z, bt, r;
        logic [1:0] c;
        int op, j;
        n_cmp = 0; n_bad = 0;
        m_addr = 0; m_mode = M_IDLE; m_ill = 1'b0;
        rstn = 1'b0;
        bus.start = 1'b0; bus.stall = 1'b0; bus.z_flag = 1'b0; bus.BT = 1'b0;
        bus.condition = 2'b00; bus.opcode = '0; bus.jump_addr = '0;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);

        // start, unconditional next, legal and illegal dispatch
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        nop_jump(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 12, 5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 90, 5);
        nop_jump(3);

        // conditional branches around 60
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        nop_jump(60);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 0, 62);
        nop_jump(60);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 0, 62);
        nop_jump(60);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 0, 62);
        nop_jump(60);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 0, 62);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, 70);

        // stall beats dispatch, then dispatch on release
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 20, 9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 20, 9);

        // halt at the end self-loop, idle in HALT, restart
        nop_jump(80);
        nop_jump(80);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 4, 7);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        nop_jump(40);

        // reset in the middle of RUN, then jump_addr=0 returns to IDLE quietly
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 50);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 50);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        nop_jump(0);

        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 199) != 0);
            st = ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 4) == 0);
            z  = 1'($urandom_range(0, 1));
            bt = ($urandom_range(0, 9) == 0);
            c  = 2'($urandom_range(0, 3));
            op = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 85)) : int'($urandom_range(0, 255));
            j  = ($urandom_range(0, 3) == 0) ? ENDA : int'($urandom_range(0, 127));
            drive(r, st, sl, z, bt, c, op, j);
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
